io_register_responder: RTL and testbench
========================================

Name: io_register_responder

Overview:
- Full read/write responder on the lisp_core register bus (register_index / register_read / register_write / register_write_value / register_read_value).
- Replaces the write-only LED latch at the top level.
- Serves the core's register reads from:
  - switch inputs
  - a free-running tick timer
  - a byte-receive FIFO fed by an external serial receiver.
- Sits between lisp_core and board I/O in the top-level module.

Parameters:
- FIFO_DEPTH, 16, RX byte FIFO entries; power of two, 2..128.
- TICK_DIV, 50000, clk cycles per TICK increment; ≥1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- register_index  input  7  register address from core.
- register_read  input  1  read strobe, one cycle per access.
- register_write  input  1  write strobe, one cycle per access.
- register_write_value  input  16  write data.
- register_read_value  output  16  registered read data.
- led_out  output  8  LED register contents.
- switches_in  input  8  asynchronous switch inputs.
- rx_valid  input  1  one-cycle strobe, rx_data valid.
- rx_data  input  8  received byte.

Behaviour:
Reset and timing
- Reset (synchronous, active-high) clears: register_read_value, led_out, TICK, prescaler, FIFO pointers/count, switch synchronizers, sticky flag.
- Reset mid-stream discards FIFO contents.
- rx_valid during reset is ignored.
- Read latency is 1 cycle: on the edge where register_read=1, register_read_value loads the selected register. When register_read=0 it holds its value.

Register map
- 0x00 LED, R/W: write loads led_out from write_value[7:0]; read returns {8'h00, led_out}.
- 0x01 SWITCH, RO: two-flop synchronized switches_in, zero-extended.
- 0x02 TICK, R/W: 16-bit counter.
  - Prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 the prescaler returns to 0 and TICK increments.
  - TICK wraps 0xFFFF→0x0000.
  - Write loads TICK from write_value and clears the prescaler.
  - Write wins over increment in the same cycle.
- 0x03 RX_DATA, RO with pop: returns {8'h00, head byte} and pops. If empty, returns 0x0000 with no pointer change.
- 0x04 STATUS, RO:
  - bit0 empty, bit1 full, bit2 overflow (optional feature), bits[15:8] count.
  - Other bits 0.
- All other indices: read 0x0000; writes ignored.
- Simultaneous read and write to the same index: read returns the pre-write value; write takes effect.

RX FIFO
- Push on rx_valid when not full, or when full and an RX_DATA pop occurs in the same cycle.
- Otherwise the byte is dropped.
- Push and pop while empty: pop returns 0x0000, push is accepted; no bypass.
- Count is always in the range 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- RX_OVERFLOW_STICKY_EN defined:
  - STATUS bit2 is set on any dropped byte and stays set.
  - Cleared by a STATUS write with write_value[2]=1.
  - If a drop and the clear occur in the same cycle, set wins.
- RX_OVERFLOW_STICKY_EN undefined: STATUS bit2 reads 0 and STATUS writes are ignored.

Decomposition:
- Package io_register_pkg holds:
  - register index constants REG_LED, REG_SWITCH, REG_TICK, REG_RX_DATA, REG_STATUS;
  - STATUS bit positions;
  - bus widths (index 7, data 16).
- One sub-module, io_rx_fifo: synchronous FIFO with parameter DEPTH, ports push/pop/data/empty/full/count. It has no register-bus knowledge.
- The decoder, tick timer and synchronizer stay in the top module.

Test Plan:
- Reset, then write 0x00A5 to index 0x00, then read 0x00 → led_out=0xA5 the next cycle; register_read_value=0x00A5 one cycle after the read strobe.
- TICK_DIV=4: write 0xFFFE to 0x02, run 8 cycles, read 0x02 → 0x0000 (wrap). Write on the increment cycle → written value kept.
- Push 0x11, 0x22, 0x33; read 0x04 → 0x0300. Three reads of 0x03 → 0x0011, 0x0022, 0x0033. Fourth read → 0x0000; STATUS → 0x0001.
- FIFO_DEPTH=4: push 5 bytes → STATUS=0x0402, fifth byte lost (with RX_OVERFLOW_STICKY_EN: 0x0406). Clear via write 0x0004 → bit2=0. Pop+push while full → count stays 4, no overflow.
- Switches 0x3C applied → read 0x01 returns 0x003C only after 2 sync cycles (read at cycle +1 returns old value). Read index 0x7F → 0x0000.
- Assert reset with 3 bytes queued and led_out=0xFF → next cycle: STATUS=0x0001, led_out=0x00, register_read_value=0x0000.

Source files
------------

// File: rtl/io_register_pkg.sv
// Shared register-bus constants for the board I/O responder: register indices,
// STATUS bit positions and bus widths.
package io_register_pkg;

  localparam int unsigned INDEX_W = 7;
  localparam int unsigned DATA_W  = 16;

  localparam logic [INDEX_W-1:0] REG_LED     = 7'h00;
  localparam logic [INDEX_W-1:0] REG_SWITCH  = 7'h01;
  localparam logic [INDEX_W-1:0] REG_TICK    = 7'h02;
  localparam logic [INDEX_W-1:0] REG_RX_DATA = 7'h03;
  localparam logic [INDEX_W-1:0] REG_STATUS  = 7'h04;

  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_OVF_BIT   = 2;

endpackage

// File: rtl/io_rx_fifo.sv
// Synchronous FIFO with occupancy count. Pushing while full is accepted only
// when a pop happens in the same cycle; popping an empty FIFO does nothing.
module io_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW + 1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW + 1)'(1);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/io_register_responder.sv
// Read/write responder on the core register bus: LEDs, synchronized switches,
// tick timer and RX byte FIFO. Define RX_OVERFLOW_STICKY_EN for the STATUS overflow flag.
module io_register_responder
  import io_register_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TICK_DIV   = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] register_index,
  input  logic               register_read,
  input  logic               register_write,
  input  logic [DATA_W-1:0]  register_write_value,
  output logic [DATA_W-1:0]  register_read_value,
  output logic [7:0]         led_out,
  input  logic [7:0]         switches_in,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]         led_q, led_d;
  logic [7:0]         sw_meta_q, sw_sync_q;
  logic [DATA_W-1:0]  tick_q, tick_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d, rd_mux, status;

  logic             wr_led, wr_tick, rd_rx;
  logic             fifo_push, fifo_pop, fifo_empty, fifo_full, ovf_flag;
  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;

  assign wr_led  = register_write && (register_index == REG_LED);
  assign wr_tick = register_write && (register_index == REG_TICK);
  assign rd_rx   = register_read && (register_index == REG_RX_DATA);

  assign fifo_pop  = rd_rx && !fifo_empty;
  assign fifo_push = rx_valid && (!fifo_full || fifo_pop);

  io_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (rx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

`ifdef RX_OVERFLOW_STICKY_EN
  logic ovf_q, ovf_d, wr_status, rx_drop;

  assign wr_status = register_write && (register_index == REG_STATUS);
  assign rx_drop   = rx_valid && !fifo_push;

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_status && register_write_value[STATUS_OVF_BIT]) ovf_d = 1'b0;
    if (rx_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_flag = ovf_q;
`else
  assign ovf_flag = 1'b0;
`endif

  always_comb begin
    tick_d  = tick_q;
    presc_d = presc_q;
    if (wr_tick) begin
      tick_d  = register_write_value;
      presc_d = '0;
    end else if (presc_q == PRESC_MAX) begin
      tick_d  = tick_q + 16'd1;
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  assign led_d = wr_led ? register_write_value[7:0] : led_q;

  always_comb begin
    status                   = '0;
    status[STATUS_EMPTY_BIT] = fifo_empty;
    status[STATUS_FULL_BIT]  = fifo_full;
    status[STATUS_OVF_BIT]   = ovf_flag;
    status[15:8]             = 8'(fifo_count);
  end

  // Mux reads current state, so a same-cycle write is seen on the next read.
  always_comb begin
    rd_mux = '0;
    case (register_index)
      REG_LED:     rd_mux = {8'h00, led_q};
      REG_SWITCH:  rd_mux = {8'h00, sw_sync_q};
      REG_TICK:    rd_mux = tick_q;
      REG_RX_DATA: rd_mux = fifo_empty ? 16'h0000 : {8'h00, fifo_head};
      REG_STATUS:  rd_mux = status;
      default:     rd_mux = '0;
    endcase
  end

  assign rdata_d = register_read ? rd_mux : rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      tick_q    <= '0;
      presc_q   <= '0;
      rdata_q   <= '0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= switches_in;
      sw_sync_q <= sw_meta_q;
      tick_q    <= tick_d;
      presc_q   <= presc_d;
      rdata_q   <= rdata_d;
    end
  end

  assign register_read_value = rdata_q;
  assign led_out             = led_q;

endmodule

// File: tb/tb_io_register_responder.sv
// Scoreboard bench for io_register_responder with FIFO_DEPTH=4, TICK_DIV=4;
// expected read data is queued when a read is driven and checked a cycle later.
module tb_io_register_responder;
  import io_register_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  register_index;
  logic        register_read;
  logic        register_write;
  logic [15:0] register_write_value;
  logic [15:0] register_read_value;
  logic [7:0]  led_out;
  logic [7:0]  switches_in;
  logic        rx_valid;
  logic [7:0]  rx_data;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [15:0] exp_q [$];
  string       tag_q [$];
  logic [15:0] sb_exp;
  string       sb_tag;
  logic        rd_fire;

`ifdef RX_OVERFLOW_STICKY_EN
  localparam logic [15:0] FULL_DROP_STATUS = 16'h0406;
`else
  localparam logic [15:0] FULL_DROP_STATUS = 16'h0402;
`endif

  io_register_responder #(
    .FIFO_DEPTH (4),
    .TICK_DIV   (4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .register_index       (register_index),
    .register_read        (register_read),
    .register_write       (register_write),
    .register_write_value (register_write_value),
    .register_read_value  (register_read_value),
    .led_out              (led_out),
    .switches_in          (switches_in),
    .rx_valid             (rx_valid),
    .rx_data              (rx_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  // Inputs are applied at a falling edge and sampled by the following rising edge.
  task automatic drive(input logic rd, input logic wr, input logic [6:0] idx,
                       input logic [15:0] wv, input logic rxv, input logic [7:0] rxd);
    register_read        = rd;
    register_write       = wr;
    register_index       = idx;
    register_write_value = wv;
    rx_valid             = rxv;
    rx_data              = rxd;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 7'h00, 16'h0000, 1'b0, 8'h00);
  endtask

  task automatic do_write(input logic [6:0] idx, input logic [15:0] val);
    drive(1'b0, 1'b1, idx, val, 1'b0, 8'h00);
  endtask

  task automatic do_read(input logic [6:0] idx, input logic [15:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    drive(1'b1, 1'b0, idx, 16'h0000, 1'b0, 8'h00);
  endtask

  task automatic push_rx(input logic [7:0] b);
    drive(1'b0, 1'b0, 7'h00, 16'h0000, 1'b1, b);
  endtask

  always @(posedge clk) rd_fire <= register_read;

  always @(negedge clk) begin
    if (rd_fire === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 16'(exp_q.size()), 16'd1);
      end else begin
        sb_exp = exp_q.pop_front();
        sb_tag = tag_q.pop_front();
        check_eq(sb_tag, register_read_value, sb_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    switches_in = 8'h00;
    register_read = 1'b0; register_write = 1'b0; register_index = '0;
    register_write_value = '0; rx_valid = 1'b0; rx_data = '0;
    @(negedge clk);
    idle(3);
    reset = 1'b0;
    check_eq("rst_rdata", register_read_value, 16'h0000);
    check_eq("rst_led", 16'(led_out), 16'h0000);
    do_read(REG_STATUS, 16'h0001, "rst_status");

    // LED write/read, and same-cycle read+write returning the old value
    do_write(REG_LED, 16'h00A5);
    check_eq("led_out", 16'(led_out), 16'h00A5);
    do_read(REG_LED, 16'h00A5, "led_rd");
    exp_q.push_back(16'h00A5);
    tag_q.push_back("led_rw_same");
    drive(1'b1, 1'b1, REG_LED, 16'h005A, 1'b0, 8'h00);
    do_read(REG_LED, 16'h005A, "led_after_rw");

    // Tick wrap and write-beats-increment
    do_write(REG_TICK, 16'hFFFE);
    idle(8);
    do_read(REG_TICK, 16'h0000, "tick_wrap");
    do_write(REG_TICK, 16'h1234);
    idle(3);
    do_write(REG_TICK, 16'h5555);
    do_read(REG_TICK, 16'h5555, "tick_wr_wins");

    // FIFO ordering and empty pop
    push_rx(8'h11); push_rx(8'h22); push_rx(8'h33);
    do_read(REG_STATUS, 16'h0300, "status_3");
    do_read(REG_RX_DATA, 16'h0011, "rx_0");
    do_read(REG_RX_DATA, 16'h0022, "rx_1");
    do_read(REG_RX_DATA, 16'h0033, "rx_2");
    do_read(REG_RX_DATA, 16'h0000, "rx_empty");
    do_read(REG_STATUS, 16'h0001, "status_empty");

    // Overflow, clear, pop+push while full
    for (int i = 0; i < 5; i++) push_rx(8'hA0 + 8'(i));
    do_read(REG_STATUS, FULL_DROP_STATUS, "status_drop");
    do_write(REG_STATUS, 16'h0004);
    do_read(REG_STATUS, 16'h0402, "status_clr");
    exp_q.push_back(16'h00A0);
    tag_q.push_back("poppush");
    drive(1'b1, 1'b0, REG_RX_DATA, 16'h0000, 1'b1, 8'hB0);
    do_read(REG_STATUS, 16'h0402, "status_poppush");
    do_read(REG_RX_DATA, 16'h00A1, "drain_0");
    do_read(REG_RX_DATA, 16'h00A2, "drain_1");
    do_read(REG_RX_DATA, 16'h00A3, "drain_2");
    do_read(REG_RX_DATA, 16'h00B0, "drain_3");
    do_read(REG_STATUS, 16'h0001, "status_drained");

    // Switch synchronizer latency and unmapped index
    switches_in = 8'h3C;
    do_read(REG_SWITCH, 16'h0000, "sw_c0");
    do_read(REG_SWITCH, 16'h0000, "sw_c1");
    do_read(REG_SWITCH, 16'h003C, "sw_c2");
    do_write(7'h7F, 16'hFFFF);
    do_read(7'h7F, 16'h0000, "unmapped");
    do_read(REG_LED, 16'h005A, "led_unmapped_wr");

    // Reset with data queued; rx_valid during reset is ignored
    do_write(REG_LED, 16'h00FF);
    push_rx(8'h01); push_rx(8'h02); push_rx(8'h03);
    do_read(REG_LED, 16'h00FF, "pre_rst_led");
    reset = 1'b1;
    drive(1'b0, 1'b0, 7'h00, 16'h0000, 1'b1, 8'h77);
    reset = 1'b0;
    check_eq("mid_rst_led", 16'(led_out), 16'h0000);
    check_eq("mid_rst_rdata", register_read_value, 16'h0000);
    do_read(REG_STATUS, 16'h0001, "mid_rst_status");
    do_read(REG_RX_DATA, 16'h0000, "mid_rst_rx");

    idle(2);
    check_eq("sb_drain", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
